port_rd_frontend: RTL and testbench

Egress-side frontend of a switch port: accepts 16-bit packet words streamed from the port backend (`xfer_data_vld`/`xfer_data`/`end_of_packet`) into a 64-entry buffer. It replays them onto the external read interface as `rd_sop`, a run of `rd_vld`/`rd_data` words and `rd_eop`, paced by the downstream `ready`. It is the read-direction counterpart of the port write frontend and returns backpressure to the backend through `xfer_pause`.

---
 rtl/port_pkg.sv | 26 ++
 rtl/port_rd_frontend_if.sv | 26 ++
 rtl/port_rd_fifo.sv | 65 ++++++
 rtl/port_rd_frontend.sv | 104 ++++++++++
 tb/tb_port_rd_frontend.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/port_pkg.sv
// Shared types for the switch port frontends: word width, read FSM states,
// buffer entry layout and packet header field positions.
package port_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOP  = 2'd1,
    DATA = 2'd2,
    EOP  = 2'd3
  } rd_state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } buf_entry_t;

  // First word of every packet: length[15:7], prior[6:4], dest[3:0]
  typedef struct packed {
    logic [8:0] length;
    logic [2:0] prior;
    logic [3:0] dest;
  } pkt_hdr_t;

endpackage

// File: rtl/port_rd_frontend_if.sv
// Backend word stream, backpressure and downstream read bus of one port.
interface port_rd_frontend_if;
  import port_pkg::*;

  logic              xfer_data_vld;
  logic [DATA_W-1:0] xfer_data;
  logic              end_of_packet;
  logic              xfer_pause;
  logic              ready;
  logic              rd_sop;
  logic              rd_vld;
  logic [DATA_W-1:0] rd_data;
  logic              rd_eop;
  logic              overflow;

  modport master (
    input  xfer_data_vld, xfer_data, end_of_packet, ready,
    output xfer_pause, rd_sop, rd_vld, rd_data, rd_eop, overflow
  );

  modport slave (
    output xfer_data_vld, xfer_data, end_of_packet, ready,
    input  xfer_pause, rd_sop, rd_vld, rd_data, rd_eop, overflow
  );

endinterface

// File: rtl/port_rd_fifo.sv
// Synchronous DEPTH x {last,data} word buffer with occupancy count and a
// sticky flag for writes dropped while full.
module port_rd_fifo
  import port_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  buf_entry_t                 wr_entry,
  input  logic                       pop,
  output buf_entry_t                 rd_entry_c,
  output logic [$clog2(DEPTH):0]     word_cnt,
  output logic [$clog2(DEPTH):0]     word_cnt_nxt_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  buf_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_c     = (word_cnt == CW'(DEPTH));
  assign empty_c    = (word_cnt == '0);
  assign do_push    = push && !full_c;
  assign do_pop     = pop && !empty_c;
  assign rd_entry_c = mem[rd_ptr];

  always_comb begin
    word_cnt_nxt_c = word_cnt;
    if (do_push && !do_pop) begin
      word_cnt_nxt_c = word_cnt + CW'(1);
    end else if (!do_push && do_pop) begin
      word_cnt_nxt_c = word_cnt - CW'(1);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      word_cnt <= word_cnt_nxt_c;
      if (push && full_c) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy is defined by the pointers alone
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/port_rd_frontend.sv
// Egress read frontend: buffers backend packet words and replays them as
// sop / vld+data / eop on the downstream bus, paced by ready.
module port_rd_frontend
  import port_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned START_TH = 32,
  parameter int unsigned PAUSE_TH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  port_rd_frontend_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  rd_state_t     state;
  rd_state_t     state_nxt;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] pkt_cnt_nxt;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] word_cnt_nxt_c;
  logic          full_c;
  logic          empty_c;
  logic          push_c;
  logic          pop_c;
  logic          push_last_c;
  logic          pop_last_c;
  logic          pause_nxt_c;
  logic          fifo_overflow;
  buf_entry_t    wr_entry;
  buf_entry_t    rd_entry_c;

  port_rd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk            (clk),
    .rst_n          (rst_n),
    .push           (bus.xfer_data_vld),
    .wr_entry       (wr_entry),
    .pop            (pop_c),
    .rd_entry_c     (rd_entry_c),
    .word_cnt       (word_cnt),
    .word_cnt_nxt_c (word_cnt_nxt_c),
    .full_c         (full_c),
    .empty_c        (empty_c),
    .overflow       (fifo_overflow)
  );

  assign wr_entry     = '{last: bus.end_of_packet, data: bus.xfer_data};
  assign push_c       = bus.xfer_data_vld && !full_c;
  assign pop_c        = (state == DATA) && bus.ready && !empty_c;
  assign push_last_c  = push_c && bus.end_of_packet;
  assign pop_last_c   = pop_c && rd_entry_c.last;
  assign pause_nxt_c  = (CW'(DEPTH) - word_cnt_nxt_c) <= CW'(PAUSE_TH);
  assign bus.overflow = fifo_overflow;

  // A packet may start once it is complete or enough of it is buffered
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.ready && (pkt_cnt != '0 || word_cnt >= CW'(START_TH))) state_nxt = SOP;
      SOP:  state_nxt = DATA;
      DATA: if (pop_last_c) state_nxt = EOP;
      EOP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pkt_cnt_nxt = pkt_cnt;
    if (push_last_c && !pop_last_c) begin
      pkt_cnt_nxt = pkt_cnt + CW'(1);
    end else if (!push_last_c && pop_last_c) begin
      pkt_cnt_nxt = pkt_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pkt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pkt_cnt <= pkt_cnt_nxt;
    end
  end

  // rd_data only moves on a pop so it holds across rd_vld gaps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rd_sop     <= 1'b0;
      bus.rd_vld     <= 1'b0;
      bus.rd_data    <= '0;
      bus.rd_eop     <= 1'b0;
      bus.xfer_pause <= 1'b0;
    end else begin
      bus.rd_sop     <= (state_nxt == SOP);
      bus.rd_vld     <= pop_c;
      bus.rd_eop     <= (state == EOP);
      bus.xfer_pause <= pause_nxt_c;
      if (pop_c) bus.rd_data <= rd_entry_c.data;
    end
  end

endmodule

// File: tb/tb_port_rd_frontend.sv
// Directed bench for port_rd_frontend: cycle tables for short packets plus
// hand-written sequences for threshold start, fill/overflow and reset.
module tb_port_rd_frontend;
  import port_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  port_rd_frontend_if bus ();

  port_rd_frontend dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [15:0] data;
    logic        eop;
    logic        rdy;
    logic        x_sop;
    logic        x_vld;
    logic [15:0] x_data;
    logic        x_eop;
    rd_state_t   x_state;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;
  int   tbl_a, tbl_b, tbl_c, tbl_end;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [15:0] d, input logic eop, input logic rdy,
                     input logic s, input logic v, input logic [15:0] xd, input logic e,
                     input rd_state_t st);
    vec_t r;
    r.vld = vld; r.data = d; r.eop = eop; r.rdy = rdy;
    r.x_sop = s; r.x_vld = v; r.x_data = xd; r.x_eop = e; r.x_state = st;
    tbl.push_back(r);
  endtask

  task automatic idle_inputs();
    bus.xfer_data_vld = 1'b0;
    bus.xfer_data     = 16'h0000;
    bus.end_of_packet = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [15:0] d, input logic eop);
    bus.xfer_data_vld = 1'b1;
    bus.xfer_data     = d;
    bus.end_of_packet = eop;
  endtask

  // Each row: inputs held for one cycle, registered outputs checked after the edge
  task automatic run_table(input string name, input int first, input int last);
    for (int i = first; i < last; i++) begin
      bus.xfer_data_vld = tbl[i].vld;
      bus.xfer_data     = tbl[i].data;
      bus.end_of_packet = tbl[i].eop;
      bus.ready         = tbl[i].rdy;
      step();
      chk($sformatf("%s row %0d", name, i - first),
          32'({bus.rd_sop, bus.rd_vld, bus.rd_data, bus.rd_eop, bus.xfer_pause, dut.state}),
          32'({tbl[i].x_sop, tbl[i].x_vld, tbl[i].x_data, tbl[i].x_eop, 1'b0, tbl[i].x_state}));
    end
    idle_inputs();
  endtask

  task automatic build_tables();
    // 4-word packet, ready held high
    tbl_a = tbl.size();
    add(1, 16'h0213, 0, 1,  0, 0, 16'h0000, 0, IDLE);
    add(1, 16'hA001, 0, 1,  0, 0, 16'h0000, 0, IDLE);
    add(1, 16'hA002, 0, 1,  0, 0, 16'h0000, 0, IDLE);
    add(1, 16'hA003, 1, 1,  0, 0, 16'h0000, 0, IDLE);
    add(0, 16'h0000, 0, 1,  1, 0, 16'h0000, 0, SOP);
    add(0, 16'h0000, 0, 1,  0, 0, 16'h0000, 0, DATA);
    add(0, 16'h0000, 0, 1,  0, 1, 16'h0213, 0, DATA);
    add(0, 16'h0000, 0, 1,  0, 1, 16'hA001, 0, DATA);
    add(0, 16'h0000, 0, 1,  0, 1, 16'hA002, 0, DATA);
    add(0, 16'h0000, 0, 1,  0, 1, 16'hA003, 0, EOP);
    add(0, 16'h0000, 0, 1,  0, 0, 16'hA003, 1, IDLE);
    add(0, 16'h0000, 0, 1,  0, 0, 16'hA003, 0, IDLE);
    // Same packet, ready low for 3 cycles after the first word
    tbl_b = tbl.size();
    add(1, 16'h0213, 0, 1,  0, 0, 16'h0000, 0, IDLE);
    add(1, 16'hA001, 0, 1,  0, 0, 16'h0000, 0, IDLE);
    add(1, 16'hA002, 0, 1,  0, 0, 16'h0000, 0, IDLE);
    add(1, 16'hA003, 1, 1,  0, 0, 16'h0000, 0, IDLE);
    add(0, 16'h0000, 0, 1,  1, 0, 16'h0000, 0, SOP);
    add(0, 16'h0000, 0, 1,  0, 0, 16'h0000, 0, DATA);
    add(0, 16'h0000, 0, 1,  0, 1, 16'h0213, 0, DATA);
    add(0, 16'h0000, 0, 0,  0, 0, 16'h0213, 0, DATA);
    add(0, 16'h0000, 0, 0,  0, 0, 16'h0213, 0, DATA);
    add(0, 16'h0000, 0, 0,  0, 0, 16'h0213, 0, DATA);
    add(0, 16'h0000, 0, 1,  0, 1, 16'hA001, 0, DATA);
    add(0, 16'h0000, 0, 1,  0, 1, 16'hA002, 0, DATA);
    add(0, 16'h0000, 0, 1,  0, 1, 16'hA003, 0, EOP);
    add(0, 16'h0000, 0, 1,  0, 0, 16'hA003, 1, IDLE);
    add(0, 16'h0000, 0, 1,  0, 0, 16'hA003, 0, IDLE);
    // Two 1-word packets back to back
    tbl_c = tbl.size();
    add(1, 16'h0081, 1, 1,  0, 0, 16'h0000, 0, IDLE);
    add(1, 16'h0092, 1, 1,  1, 0, 16'h0000, 0, SOP);
    add(0, 16'h0000, 0, 1,  0, 0, 16'h0000, 0, DATA);
    add(0, 16'h0000, 0, 1,  0, 1, 16'h0081, 0, EOP);
    add(0, 16'h0000, 0, 1,  0, 0, 16'h0081, 1, IDLE);
    add(0, 16'h0000, 0, 1,  1, 0, 16'h0081, 0, SOP);
    add(0, 16'h0000, 0, 1,  0, 0, 16'h0081, 0, DATA);
    add(0, 16'h0000, 0, 1,  0, 1, 16'h0092, 0, EOP);
    add(0, 16'h0000, 0, 1,  0, 0, 16'h0092, 1, IDLE);
    add(0, 16'h0000, 0, 1,  0, 0, 16'h0092, 0, IDLE);
    tbl_end = tbl.size();
  endtask

  function automatic logic [15:0] big_word(input int i);
    logic [15:0] w;
    w = (i == 0) ? 16'h3213 : 16'h1000 + 16'(i);
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx, rx, sop_at, sop_n, maxwc, vcount, stray;
    logic done;

    rst_n = 1'b0;
    bus.ready = 1'b0;
    idle_inputs();
    build_tables();
    step();
    step();
    chk("reset outputs",
        32'({bus.rd_sop, bus.rd_vld, bus.rd_data, bus.rd_eop, bus.xfer_pause, bus.overflow}), 32'd0);
    chk("reset counts", 32'({dut.u_fifo.word_cnt, dut.pkt_cnt, dut.state}), 32'd0);
    rst_n = 1'b1;

    run_table("pkt4", tbl_a, tbl_b);
    chk("pkt4 pkt_cnt", 32'(dut.pkt_cnt), 32'd0);
    chk("pkt4 word_cnt", 32'(dut.u_fifo.word_cnt), 32'd0);

    do_reset();
    run_table("pkt4_stall", tbl_b, tbl_c);
    chk("stall pkt_cnt", 32'(dut.pkt_cnt), 32'd0);

    do_reset();
    run_table("two_1w", tbl_c, tbl_end);

    // 100-word packet: starts on the START_TH threshold, pushes honour pause
    do_reset();
    bus.ready = 1'b1;
    tx = 0; rx = 0; sop_at = -1; sop_n = 0; maxwc = 0; done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (tx < 100 && !bus.xfer_pause) begin
        push(big_word(tx), tx == 99);
        tx++;
      end else begin
        idle_inputs();
      end
      step();
      if (bus.rd_sop) begin
        sop_n++;
        if (sop_at < 0) sop_at = tx;
      end
      if (bus.rd_vld) begin
        if (rx < 100) chk($sformatf("big word %0d", rx), 32'(bus.rd_data), 32'(big_word(rx)));
        rx++;
      end
      if (int'(dut.u_fifo.word_cnt) > maxwc) maxwc = int'(dut.u_fifo.word_cnt);
      if (bus.rd_eop) done = 1'b1;
    end
    idle_inputs();
    chk("big sop at 33 words pushed", 32'(sop_at), 32'd33);
    chk("big sop count", 32'(sop_n), 32'd1);
    chk("big word count", 32'(rx), 32'd100);
    chk("big eop seen", 32'(done), 32'd1);
    chk("big word_cnt max <= 64", 32'(maxwc <= 64), 32'd1);

    // Fill with ready low, then overrun by one word
    do_reset();
    bus.ready = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      push(16'h5000 + 16'(k), 1'b0);
      step();
      if (k == 59) chk("fill pause at 59", 32'(bus.xfer_pause), 32'd0);
      if (k == 60) chk("fill pause at 60", 32'(bus.xfer_pause), 32'd1);
    end
    chk("fill word_cnt 64", 32'(dut.u_fifo.word_cnt), 32'd64);
    chk("fill no overflow yet", 32'(bus.overflow), 32'd0);
    push(16'h5FFF, 1'b0);
    step();
    idle_inputs();
    chk("overrun overflow", 32'(bus.overflow), 32'd1);
    chk("overrun word_cnt", 32'(dut.u_fifo.word_cnt), 32'd64);
    repeat (3) step();
    chk("overflow sticky", 32'({bus.overflow, bus.xfer_pause, bus.rd_sop}), 32'b110);

    // Reset in the middle of delivery, then a fresh packet
    do_reset();
    bus.ready = 1'b1;
    push(16'h0213, 1'b0); step();
    push(16'hA001, 1'b0); step();
    push(16'hA002, 1'b0); step();
    push(16'hA003, 1'b1); step();
    idle_inputs();
    vcount = 0;
    for (int cyc = 0; cyc < 20 && vcount < 2; cyc++) begin
      step();
      if (bus.rd_vld) vcount++;
    end
    chk("midrst reached 2nd word", 32'(vcount), 32'd2);
    rst_n = 1'b0;
    step();
    chk("midrst outputs",
        32'({bus.rd_sop, bus.rd_vld, bus.rd_data, bus.rd_eop, bus.xfer_pause, bus.overflow}), 32'd0);
    chk("midrst counts", 32'({dut.u_fifo.word_cnt, dut.pkt_cnt, dut.state}), 32'd0);
    rst_n = 1'b1;
    stray = 0;
    repeat (4) begin
      step();
      if (bus.rd_sop || bus.rd_vld || bus.rd_eop) stray++;
    end
    chk("midrst no stray output", 32'(stray), 32'd0);
    run_table("after_rst", tbl_a, tbl_b);
    chk("after_rst pkt_cnt", 32'(dut.pkt_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
